// File: rtl/mult_div_if.sv
// Multiply/divide unit interface.
// Groups the EX-stage request, the ID-stage hazard query and the HI/LO results.
//   start     : EX-stage multiply-class instruction valid this cycle
//   op        : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled only with start)
//   a, b      : forwarded rs/rt operands
//   id_md_use : ID-stage instruction is multiply-class or MFHI/MFLO
//   busy      : operation in flight
//   md_stall  : stall request to the hazard logic
//   hi, lo    : architectural HI/LO registers
interface mult_div_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        id_md_use;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: issues operations, consumes status and HI/LO.
    modport master (
        output start, op, a, b, id_md_use,
        input  busy, md_stall, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, op, a, b, id_md_use,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning the HI/LO register pair.
// The result is computed when the operation is accepted and held as a pending
// value; a countdown models the latency, and the pending value is committed to
// HI/LO on the last busy cycle.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   md    : mult_div_if slave (start/op/a/b/id_md_use in, busy/md_stall/hi/lo out)
module mult_div_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input logic       clk,
    input logic       reset,
    mult_div_if.slave md
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       pend_hi_q, pend_hi_d;
    logic [31:0]       pend_lo_q, pend_lo_d;

    // ---------------------------------------------------------------------
    // Result datapath
    // ---------------------------------------------------------------------
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quo_s, rem_s;
    logic [31:0] quo_u, rem_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] res_hi, res_lo;

    // Sign-extend to 64 bits so the low 64 bits of the product are exact.
    assign prod_s = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
    assign prod_u = {32'd0, md.a} * {32'd0, md.b};

    // Signed '/' truncates toward zero and '%' follows the dividend sign.
    assign quo_s = $signed(md.a) / $signed(md.b);
    assign rem_s = $signed(md.a) % $signed(md.b);
    assign quo_u = md.a / md.b;
    assign rem_u = md.a % md.b;

    assign div_zero = (md.b == 32'd0);
    // Most-negative / -1 overflows; pin the result rather than rely on the operator.
    assign div_ovf  = (md.a == 32'h8000_0000) && (md.b == 32'hFFFF_FFFF);

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        unique case (md.op)
            2'b00: {res_hi, res_lo} = prod_s;
            2'b01: {res_hi, res_lo} = prod_u;
            2'b10: begin
                if (div_zero) begin
                    res_hi = md.a;
                    res_lo = 32'hFFFF_FFFF;
                end else if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            2'b11: begin
                if (div_zero) begin
                    res_hi = md.a;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        unique case (state_q)
            StIdle: begin
                if (md.start) begin
                    state_d   = StRun;
                    cnt_d     = md.op[1] ? CntW'(DIV_CYCLES) : CntW'(MUL_CYCLES);
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                end
            end
            StRun: begin
                // start is ignored here; operands were captured at acceptance.
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        md.busy     = (state_q == StRun);
        // Stall also in the accept cycle so a following MFHI/MFLO cannot slip past.
        md.md_stall = md.id_md_use & ((state_q == StRun) | md.start);
        md.hi       = hi_q;
        md.lo       = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mult_div_if md_if ();

    mult_div_unit #(
        .MUL_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (md_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble operands afterward, count busy and stall cycles,
    // then check busy length and the committed HI/LO.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int n, input logic [31:0] eh,
                          input logic [31:0] el, output int stalls);
        int cnt;
        md_if.start = 1'b1;
        md_if.op    = o;
        md_if.a     = x;
        md_if.b     = y;
        #1;
        stalls = md_if.md_stall ? 1 : 0;
        step();
        md_if.start = 1'b0;
        md_if.op    = ~o;
        md_if.a     = $urandom;
        md_if.b     = $urandom;
        #1;
        cnt = 0;
        for (int i = 0; i < 40 && md_if.busy; i++) begin
            cnt++;
            if (md_if.md_stall) stalls++;
            step();
        end
        check({tag, " busy cycles"}, 64'(cnt), 64'(n));
        check({tag, " hi"}, 64'(md_if.hi), 64'(eh));
        check({tag, " lo"}, 64'(md_if.lo), 64'(el));
    endtask

    initial begin
        int stalls;
        int cnt;
        logic [31:0] bad;

        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b1;
        md_if.start     = 1'b0;
        md_if.op        = 2'b00;
        md_if.a         = 32'd0;
        md_if.b         = 32'd0;
        md_if.id_md_use = 1'b1;

        // Reset
        step();
        step();
        check("reset busy", 64'(md_if.busy), 64'd0);
        check("reset hi", 64'(md_if.hi), 64'd0);
        check("reset lo", 64'(md_if.lo), 64'd0);
        check("reset md_stall", 64'(md_if.md_stall), 64'd0);
        reset           = 1'b0;
        md_if.id_md_use = 1'b0;
        step();

        // Main function
        run_op("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, stalls);
        run_op("multu", 2'b01, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, stalls);
        run_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, stalls);
        run_op("divu", 2'b11, 32'd7, 32'd2, 10, 32'd1, 32'd3, stalls);
        run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000,
               stalls);
        run_op("divu by0", 2'b11, 32'h0000_1234, 32'd0, 10, 32'h0000_1234, 32'hFFFF_FFFF,
               stalls);
        run_op("div by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF,
               stalls);
        run_op("mult pos", 2'b00, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0, stalls);

        // Stall window with id_md_use held from the start cycle
        md_if.id_md_use = 1'b1;
        run_op("stall mult", 2'b00, 32'd6, 32'd7, 5, 32'd0, 32'd42, stalls);
        check("stall cycles", 64'(stalls), 64'd6);
        check("stall released", 64'(md_if.md_stall), 64'd0);
        md_if.id_md_use = 1'b0;
        step();

        // start mid-RUN is ignored
        md_if.start = 1'b1;
        md_if.op    = 2'b00;
        md_if.a     = 32'd2;
        md_if.b     = 32'd3;
        step();
        cnt = 0;
        for (int i = 0; i < 40 && md_if.busy; i++) begin
            cnt++;
            md_if.start = (cnt == 2);
            md_if.op    = 2'b11;
            md_if.a     = 32'd100;
            md_if.b     = 32'd7;
            step();
        end
        md_if.start = 1'b0;
        check("ignore busy cycles", 64'(cnt), 64'd5);
        check("ignore hi", 64'(md_if.hi), 64'd0);
        check("ignore lo", 64'(md_if.lo), 64'd6);
        step();
        check("ignore no restart", 64'(md_if.busy), 64'd0);

        // Reset in busy cycle 4 of a DIV
        md_if.start = 1'b1;
        md_if.op    = 2'b10;
        md_if.a     = 32'd100;
        md_if.b     = 32'd7;
        step();
        md_if.start = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst mid busy", 64'(md_if.busy), 64'd0);
        check("rst mid hi", 64'(md_if.hi), 64'd0);
        check("rst mid lo", 64'(md_if.lo), 64'd0);
        bad = 32'd0;
        for (int i = 6; i <= 12; i++) begin
            step();
            bad = bad | md_if.hi | md_if.lo | {31'd0, md_if.busy};
        end
        check("rst no late commit", 64'(bad), 64'd0);

        // Reset and start together: reset wins
        reset       = 1'b1;
        md_if.start = 1'b1;
        md_if.op    = 2'b11;
        md_if.a     = 32'd9;
        md_if.b     = 32'd2;
        step();
        reset       = 1'b0;
        md_if.start = 1'b0;
        check("rst+start busy", 64'(md_if.busy), 64'd0);
        step();
        check("rst+start still idle", 64'(md_if.busy), 64'd0);
        check("rst+start lo", 64'(md_if.lo), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
